// File: rtl/wb_ddr_mem_tester.sv
// Pipelined Wishbone memory tester: writes an LFSR pattern over a word range, reads it back and compares.
// Optional watchdog abort is built when WB_DDR_MEM_TESTER_TIMEOUT_EN is defined.
module wb_ddr_mem_tester #(
  parameter int ADR_W           = 26,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 65536
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADR_W-1:0] base_adr,
  input  logic [ADR_W-1:0] num_words,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             bus_err,
  output logic             timeout,
  output logic [31:0]      err_count,
  output logic [ADR_W-1:0] first_err_adr,
  output logic [ADR_W-1:0] wb_adr,
  output logic [31:0]      wb_dat_m,
  input  logic [31:0]      wb_dat_s,
  output logic [3:0]       wb_sel,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  input  logic             wb_ack,
  input  logic             wb_stall,
  input  logic             wb_err
);

  localparam int          OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [31:0] TAPS  = 32'h80200003;

  typedef enum logic [2:0] {IDLE, WRITE, WDRAIN, READ, RDRAIN} state_t;

  state_t           state;
  logic [ADR_W-1:0] base_reg;
  logic [ADR_W-1:0] num_reg;
  logic [ADR_W-1:0] issued;
  logic [ADR_W-1:0] chk_adr;
  logic [31:0]      seed_reg;
  logic [31:0]      chk_lfsr;
  logic [OUT_W-1:0] outstanding;

  logic             accept;
  logic             ack;
  logic             rd_phase;
  logic             mismatch;
  logic             err_act;
  logic             wd_expire;
  logic             abort;
  logic [OUT_W-1:0] out_next;
  logic [ADR_W-1:0] issued_next;
  logic [31:0]      err_next;
  logic [31:0]      seed_fix;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 32'h0);
  endfunction

  assign wb_sel      = {4{wb_stb}};
  assign accept      = wb_stb & ~wb_stall;
  assign ack         = wb_ack & (outstanding != '0);
  assign rd_phase    = (state == READ) || (state == RDRAIN);
  assign mismatch    = rd_phase & ack & (wb_dat_s != chk_lfsr);
  assign err_next    = (mismatch && err_count != '1) ? err_count + 32'd1 : err_count;
  assign issued_next = issued + {{(ADR_W-1){1'b0}}, accept};
  assign seed_fix    = (seed == 32'h0) ? 32'h1 : seed;
  assign err_act     = wb_err & (state != IDLE);
  assign abort       = err_act | wd_expire;

  always_comb begin
    out_next = outstanding;
    if (accept && !ack)
      out_next = outstanding + 1'b1;
    else if (!accept && ack)
      out_next = outstanding - 1'b1;
  end

`ifdef WB_DDR_MEM_TESTER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive ack-less cycle with work in flight.
  assign wd_expire = (state != IDLE) && (outstanding != '0) && !wb_ack &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (state == IDLE || outstanding == '0 || wb_ack)
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + 1'b1;
      if (state == IDLE && start)
        timeout <= 1'b0;
      else if (wd_expire && !wb_err)
        timeout <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign wd_expire          = 1'b0;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      base_reg      <= '0;
      num_reg       <= '0;
      issued        <= '0;
      chk_adr       <= '0;
      seed_reg      <= '0;
      chk_lfsr      <= '0;
      outstanding   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      bus_err       <= 1'b0;
      err_count     <= '0;
      first_err_adr <= '0;
      wb_adr        <= '0;
      wb_dat_m      <= '0;
      wb_cyc        <= 1'b0;
      wb_stb        <= 1'b0;
      wb_we         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          base_reg      <= base_adr;
          num_reg       <= num_words;
          seed_reg      <= seed_fix;
          wb_dat_m      <= seed_fix;
          chk_lfsr      <= seed_fix;
          issued        <= '0;
          chk_adr       <= base_adr;
          wb_adr        <= base_adr;
          outstanding   <= '0;
          err_count     <= '0;
          first_err_adr <= '0;
          pass          <= 1'b0;
          bus_err       <= 1'b0;
          busy          <= 1'b1;
          wb_we         <= 1'b1;
          wb_cyc        <= (num_words != '0);
          wb_stb        <= (num_words != '0);
          state         <= WRITE;
        end
      end else if (abort) begin
        state       <= IDLE;
        wb_cyc      <= 1'b0;
        wb_stb      <= 1'b0;
        wb_we       <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b1;
        pass        <= 1'b0;
        bus_err     <= err_act;
        outstanding <= '0;
      end else begin
        outstanding <= out_next;
        err_count   <= err_next;
        if (mismatch && err_count == '0)
          first_err_adr <= chk_adr;
        if (rd_phase && ack) begin
          chk_lfsr <= lfsr_step(chk_lfsr);
          chk_adr  <= chk_adr + 1'b1;
        end
        // Address and data only move on acceptance, so they stay put while stalled.
        if (accept) begin
          issued   <= issued_next;
          wb_adr   <= wb_adr + 1'b1;
          wb_dat_m <= lfsr_step(wb_dat_m);
        end
        case (state)
          WRITE, READ: begin
            if (num_reg == '0) begin
              state  <= IDLE;
              wb_cyc <= 1'b0;
              wb_stb <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= 1'b1;
            end else if (accept && issued_next == num_reg) begin
              wb_stb <= 1'b0;
              state  <= (state == WRITE) ? WDRAIN : RDRAIN;
            end else begin
              wb_cyc <= 1'b1;
              wb_stb <= (issued_next < num_reg) && (out_next < OUT_W'(MAX_OUTSTANDING));
            end
          end
          WDRAIN: begin
            // cyc drops here for one cycle; READ raises it again with a fresh pattern.
            if (out_next == '0) begin
              state    <= READ;
              wb_cyc   <= 1'b0;
              wb_we    <= 1'b0;
              wb_dat_m <= seed_reg;
              issued   <= '0;
              wb_adr   <= base_reg;
            end
          end
          RDRAIN: begin
            if (out_next == '0) begin
              state  <= IDLE;
              wb_cyc <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_next == '0);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_ddr_mem_tester.sv
// Scoreboard bench for wb_ddr_mem_tester: a Wishbone slave model feeds a transfer and result monitor.
module tb_wb_ddr_mem_tester;
  localparam int ADR_W = 26;
  localparam int MAXO  = 8;
  localparam int TOC   = 64;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [ADR_W-1:0] base_adr;
  logic [ADR_W-1:0] num_words;
  logic [31:0]      seed;
  logic             busy, done, pass, bus_err, timeout;
  logic [31:0]      err_count;
  logic [ADR_W-1:0] first_err_adr;
  logic [ADR_W-1:0] wb_adr;
  logic [31:0]      wb_dat_m;
  logic [31:0]      wb_dat_s;
  logic [3:0]       wb_sel;
  logic             wb_cyc, wb_stb, wb_we;
  logic             wb_ack, wb_stall, wb_err;

  wb_ddr_mem_tester #(.ADR_W(ADR_W), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .num_words(num_words),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .bus_err(bus_err), .timeout(timeout),
    .err_count(err_count), .first_err_adr(first_err_adr), .wb_adr(wb_adr), .wb_dat_m(wb_dat_m),
    .wb_dat_s(wb_dat_s), .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_ack(wb_ack), .wb_stall(wb_stall), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic we; logic [ADR_W-1:0] adr; logic [31:0] dat;} xfer_t;
  typedef struct {logic pass; logic berr; logic to; logic [31:0] ec; logic [ADR_W-1:0] fa;} res_t;
  typedef struct {int ready; logic rd; logic [31:0] dat;} pend_t;

  xfer_t exp_xq[$];
  res_t  exp_rq[$];
  pend_t pend[$];
  logic [31:0] mem [logic [ADR_W-1:0]];

  int errors = 0;
  int checks = 0;
  int stall_pct = 0, max_lat = 0, err_wack = 0;
  bit no_ack = 0, flip_en = 0;
  logic [ADR_W-1:0] flip_adr = '0;
  int cyc_k = 0, tb_out = 0, wack_n = 0, pcnt = 0, done_p = 0, done_cnt = 0;
  bit cyc_seen = 0, prev_st = 0;
  logic [ADR_W-1:0] prev_adr;
  logic [31:0] prev_dat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  initial forever begin
    @(posedge clk);
    pcnt++;
  end

  // Slave model: drives stall/ack/err at negedge for the following posedge, checks each accepted transfer.
  pend_t p;
  xfer_t x;
  logic [31:0] rdat;
  initial begin
    wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0; wb_dat_s = '0;
    forever begin
      @(negedge clk);
      cyc_k++;
      if (wb_err) begin
        chk("cyc_stb_drop_after_err", {62'd0, wb_cyc, wb_stb}, 64'd0);
        pend.delete();
        tb_out = 0;
      end
      if (wb_cyc) cyc_seen = 1;
      if (prev_st && wb_stb) begin
        chk("stall_hold_adr", 64'(wb_adr), 64'(prev_adr));
        chk("stall_hold_dat", 64'(wb_dat_m), 64'(prev_dat));
      end
      wb_ack = 1'b0;
      wb_err = 1'b0;
      if (!no_ack && pend.size() > 0 && wb_cyc && pend[0].ready <= cyc_k) begin
        p = pend.pop_front();
        if (!p.rd) begin
          wack_n++;
          if (wack_n == err_wack) wb_err = 1'b1;
          else wb_ack = 1'b1;
        end else begin
          wb_ack = 1'b1;
          wb_dat_s = p.dat;
        end
        if (wb_ack) tb_out--;
      end
      wb_stall = ($urandom_range(99) < stall_pct);
      prev_st  = wb_cyc && wb_stb && wb_stall;
      prev_adr = wb_adr;
      prev_dat = wb_dat_m;
      if (wb_cyc && wb_stb && !wb_stall && !wb_err) begin
        tb_out++;
        chk("outstanding_le_max", 64'(tb_out <= MAXO), 64'd1);
        chk("sel", 64'(wb_sel), 64'hF);
        if (exp_xq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got adr %0h we %0b expected none", wb_adr, wb_we);
        end else begin
          x = exp_xq.pop_front();
          chk("xfer_we", 64'(wb_we), 64'(x.we));
          chk("xfer_adr", 64'(wb_adr), 64'(x.adr));
          if (x.we) chk("xfer_dat", 64'(wb_dat_m), 64'(x.dat));
        end
        p.ready = cyc_k + 1 + $urandom_range(max_lat, 0);
        p.rd    = !wb_we;
        if (wb_we) begin
          mem[wb_adr] = wb_dat_m;
          p.dat = '0;
        end else begin
          rdat = mem.exists(wb_adr) ? mem[wb_adr] : 32'h0;
          if (flip_en && wb_adr == flip_adr) rdat = rdat ^ 32'h1;
          p.dat = rdat;
        end
        pend.push_back(p);
      end
    end
  end

  // Result monitor: compares status against the expected record whenever done pulses.
  res_t r;
  initial forever begin
    @(negedge clk);
    if (done) begin
      done_p = pcnt;
      if (exp_rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        r = exp_rq.pop_front();
        chk("res_pass", 64'(pass), 64'(r.pass));
        chk("res_bus_err", 64'(bus_err), 64'(r.berr));
        chk("res_timeout", 64'(timeout), 64'(r.to));
        chk("res_err_count", 64'(err_count), 64'(r.ec));
        if (r.ec != 0) chk("res_first_err_adr", 64'(first_err_adr), 64'(r.fa));
        chk("res_busy_low", 64'(busy), 64'd0);
      end
      done_cnt++;
    end
  end

  task automatic run_test(input logic [ADR_W-1:0] b, input logic [ADR_W-1:0] n, input logic [31:0] s,
                          input bit e_pass, input bit e_berr, input bit e_to,
                          input logic [31:0] e_ec, input logic [ADR_W-1:0] e_fa,
                          input bit aborts, input int e_lat, input bit spurious, input string tag);
    logic [31:0] v;
    int d0, start_p, c;
    v = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < int'(n); i++) begin
      exp_xq.push_back('{1'b1, b + ADR_W'(i), v});
      v = lfsr_step(v);
    end
    for (int i = 0; i < int'(n); i++) exp_xq.push_back('{1'b0, b + ADR_W'(i), 32'h0});
    exp_rq.push_back('{e_pass, e_berr, e_to, e_ec, e_fa});
    wack_n = 0;
    cyc_seen = 0;
    mem.delete();
    d0 = done_cnt;
    @(negedge clk); #1;
    base_adr = b; num_words = n; seed = s; start = 1'b1;
    start_p = pcnt;
    @(negedge clk); #1;
    start = 1'b0;
    if (spurious) begin
      repeat (4) @(negedge clk);
      #1;
      base_adr = 26'h999; num_words = 26'd3; seed = 32'h5; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
    end
    c = 0;
    while (done_cnt == d0 && c < 4000) begin
      @(negedge clk); #1;
      c++;
    end
    if (done_cnt == d0) begin
      checks++; errors++;
      $display("FAIL %s_done_wait: got no done expected done within 4000 cycles", tag);
    end else begin
      if (e_lat > 0) chk({tag, "_latency"}, 64'(done_p - start_p), 64'(e_lat));
      if (aborts) exp_xq.delete();
      else chk({tag, "_xfers_left"}, 64'(exp_xq.size()), 64'd0);
      if (n == 0) chk({tag, "_no_cyc"}, 64'(cyc_seen), 64'd0);
      @(negedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    end
    pend.delete();
    tb_out = 0;
  endtask

  initial begin
    #5000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_adr = '0; num_words = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {56'd0, busy, done, pass, bus_err, timeout, wb_cyc, wb_stb, wb_we}, 64'd0);
    chk("reset_err_count", 64'(err_count), 64'd0);
    chk("reset_first_err_adr", 64'(first_err_adr), 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {60'd0, busy, done, wb_cyc, wb_stb}, 64'd0);

    // zero stall, one-cycle ack; a start while busy must be ignored
    run_test(26'h0, 26'd16, 32'h1, 1, 0, 0, 32'd0, '0, 0, 36, 1, "basic");
    // bit 0 flipped in read data of word 5
    flip_en = 1; flip_adr = 26'h105;
    run_test(26'h100, 26'd16, 32'h12345678, 0, 0, 0, 32'd1, 26'h105, 0, 36, 0, "flip");
    flip_en = 0;
    // random stall and ack latency, seed 0 replaced by 1
    stall_pct = 50; max_lat = 12;
    run_test(26'h2000, 26'd40, 32'h0, 1, 0, 0, 32'd0, '0, 0, 0, 0, "random");
    // address wrap at the top of the space
    stall_pct = 0; max_lat = 3;
    run_test(26'h3FFFFFE, 26'd4, 32'hDEADBEEF, 1, 0, 0, 32'd0, '0, 0, 0, 0, "wrap");
    // bus error on the third write ack, then a clean rerun
    max_lat = 0; err_wack = 3;
    run_test(26'h10, 26'd8, 32'h7, 0, 1, 0, 32'd0, '0, 1, 0, 0, "buserr");
    err_wack = 0;
    run_test(26'h40, 26'd8, 32'hA5A5A5A5, 1, 0, 0, 32'd0, '0, 0, 0, 0, "rerun");
    // empty range
    run_test(26'h55, 26'd0, 32'h3, 1, 0, 0, 32'd0, '0, 0, 2, 0, "empty");
`ifdef WB_DDR_MEM_TESTER_TIMEOUT_EN
    no_ack = 1;
    run_test(26'h0, 26'd16, 32'h1, 0, 0, 1, 32'd0, '0, 1, 66, 0, "wdog");
    no_ack = 0;
    run_test(26'h0, 26'd0, 32'h1, 1, 0, 0, 32'd0, '0, 0, 2, 0, "wdog_empty");
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_ddr_mem_tester.md
Name: wb_ddr_mem_tester

Overview:
Hardware memory-test engine acting as a pipelined Wishbone bus master. It sits directly upstream of one LiteDRAM user port (DDR_USR0 or DDR_USR1) and drives it in place of the shared bus.
- Write phase: writes an LFSR-generated pattern over a word range.
- Read phase: reads the range back and compares each word against a regenerated pattern.
- Reports pass/fail, error count and first failing address.
- Lets DDR bring-up run at full bus throughput without the Ibex core in the data path.

Parameters:
- ADR_W, 26, word-address width (26 = 256MB of 32-bit words).
- MAX_OUTSTANDING, 8, maximum issued-but-unacknowledged transactions; power of two, 2..64.
- TIMEOUT_CYCLES, 65536, cycles with outstanding>0 and no ack before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock (50MHz).
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a test when idle.
- base_adr  in  ADR_W  first word address; sampled on accepted start.
- num_words  in  ADR_W  number of words to test; sampled on accepted start.
- seed  in  32  LFSR seed; sampled on accepted start; 0 is replaced by 32'h1.
- busy  out  1  test in progress.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  last test had zero mismatches and no bus error or timeout; held until next start.
- bus_err  out  1  last test aborted on wb_err; held.
- timeout  out  1  last test aborted on watchdog; held.
- err_count  out  32  mismatch count, saturating at 32'hFFFFFFFF.
- first_err_adr  out  ADR_W  address of first mismatch; valid only if err_count != 0.
- wb_adr  out  ADR_W  Wishbone word address.
- wb_dat_m  out  32  write data.
- wb_dat_s  in  32  read data.
- wb_sel  out  4  byte select, always 4'hF while stb=1.
- wb_cyc  out  1  cycle.
- wb_stb  out  1  strobe.
- wb_we  out  1  write enable.
- wb_ack  in  1  acknowledge.
- wb_stall  in  1  pipelined stall.
- wb_err  in  1  bus error.

Behaviour:
- Reset values: all outputs 0, except first_err_adr = 0 and err_count = 0. FSM resets to IDLE.
- FSM states: IDLE -> WRITE -> WDRAIN -> READ -> RDRAIN -> IDLE.
  - start in IDLE: latch inputs, reset both LFSRs to seed, clear status, busy=1, go to WRITE.
  - start while busy: ignored.
  - num_words = 0: go straight to IDLE next cycle with done=1, pass=1, no bus traffic.
- LFSR: 32-bit Galois, polynomial taps 32'h80200003. Advances by shift-right, XORing taps when the shifted-out bit is 1.
  - Issue LFSR advances on each accepted write (stb & ~stall).
  - Check LFSR advances on each read ack.
  - The first word's data is the seed itself.
- Address: word i uses (base_adr + i) mod 2^ADR_W; wraps silently.
- Issue rule (WRITE, READ):
  - stb=1 while issued < num_words and outstanding < MAX_OUTSTANDING.
  - Transfer accepted on stb & ~stall; adr/dat are held stable while stalled.
  - cyc=1 from the first stb until outstanding returns to 0 in the drain state.
  - cyc drops for exactly one cycle between WDRAIN and READ.
- outstanding counter: +1 on accept, -1 on ack. A simultaneous accept and ack leaves it unchanged.
- WRITE -> WDRAIN when the last write is accepted. WDRAIN -> READ when outstanding = 0. At that point the issue LFSR is reset to seed and issued is reset to 0.
- READ -> RDRAIN when the last read is accepted. RDRAIN -> IDLE when outstanding = 0, with done=1 and pass=(err_count==0).
- Compare: on a read ack, wb_dat_s is compared with the check LFSR. Acks return in order.
  - Mismatch: err_count++ (saturating). If it was the first mismatch, record first_err_adr = base + check index.
- wb_err in any active state: drop cyc/stb the same cycle it is registered (next edge), set bus_err=1, pulse done, pass=0, go to IDLE.
- Outputs are registered; done is asserted in the cycle busy falls.
- Throughput: one word per cycle when stall=0 and ack latency < MAX_OUTSTANDING.

Optional Feature:
- Macro: WB_DDR_MEM_TESTER_TIMEOUT_EN.
- Defined: a watchdog counts cycles in which outstanding>0 and no ack arrives; it reloads on any ack. On reaching TIMEOUT_CYCLES, the block aborts exactly as for wb_err, but sets timeout=1 instead of bus_err.
- Undefined: no counter is built, timeout is tied to 0, and a hung slave leaves busy=1 until reset.

Test Plan:
- Slave model, zero stall, 1-cycle ack; base=0, num=16, seed=32'h1 -> 16 writes then 16 reads; done pulse; pass=1, err_count=0, busy falls after 32 transfers plus drain.
- Slave flips bit 0 of read data at word 5; base=26'h100, num=16 -> err_count=1, first_err_adr=26'h105, pass=0.
- Random stall (50%) and ack latency 0..12 with MAX_OUTSTANDING=8 -> outstanding never exceeds 8; pass=1; adr/dat stable during stall.
- base=26'h3FFFFFE, num=4 -> addresses 3FFFFFE, 3FFFFFF, 0000000, 0000001 in both phases.
- wb_err on the 3rd write ack -> cyc=0 next cycle, bus_err=1, done pulse, pass=0; a new start then runs cleanly with bus_err cleared.
- With WB_DDR_MEM_TESTER_TIMEOUT_EN and TIMEOUT_CYCLES=64: slave never acks -> timeout=1 after 64 ack-less cycles; a num=0 start gives done with pass=1 and no cyc.
